bp_update_ctrl: RTL

Sequencer for the branch-predictor tables (BTB and 2-bit PHT). It owns the single table write port. After reset, and on a software or pipeline flush request, it sweeps every entry to its cleared state. In normal operation it buffers resolved branch/jump outcomes from Execute in a small FIFO and retires one update per cycle. It sits between the Execute-stage resolution logic and the BTB/PHT write ports; the fetch-side lookup path is untouched.

---
 rtl/bp_update_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// Branch-predictor table write sequencer: sweeps BTB/PHT clear after reset or flush,
// then retires buffered Execute-stage outcomes through the single table write port.
module bp_update_ctrl #(
  parameter int SIZE     = 1024,
  parameter int PHT_SIZE = 256,
  parameter int DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_req,
  input  logic                        upd_valid,
  input  logic                        upd_is_branch,
  input  logic                        upd_is_jump,
  input  logic                        upd_taken,
  input  logic [31:0]                 upd_pc,
  input  logic [31:0]                 upd_target,
  output logic                        upd_ready,
  output logic                        busy,
  output logic                        btb_we,
  output logic [$clog2(SIZE)-1:0]     btb_idx,
  output logic                        btb_valid,
  output logic [31:0]                 btb_target,
  output logic                        pht_we,
  output logic [$clog2(PHT_SIZE)-1:0] pht_idx,
  output logic                        pht_init,
  output logic                        pht_taken,
  output logic [15:0]                 drop_cnt
);
  localparam int IW = $clog2(SIZE);
  localparam int PW = $clog2(PHT_SIZE);
  localparam int AW = $clog2(DEPTH);
  localparam logic [IW-1:0] CNT_LAST = IW'(SIZE - 1);
  localparam logic [IW:0]   PHT_LIM  = (IW+1)'(PHT_SIZE);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

  typedef struct packed {
    logic          is_br;
    logic          taken;
    logic [IW-1:0] idx;
    logic [31:0]   tgt;
  } upd_t;

  state_t        state_q;
  logic [IW-1:0] cnt_q;
  logic [AW:0]   wptr_q, rptr_q;
  logic [15:0]   drop_q;
  upd_t          fifo_q [DEPTH];
  upd_t          head;

  logic empty, full, flush, pop, typed, push, drop;
  logic unused_pc;

  assign unused_pc = ^{upd_pc[31:IW+2], upd_pc[1:0]};

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign flush = flush_req && (state_q != IDLE);
  assign pop   = (state_q == RUN) && !empty;
  assign typed = upd_valid && (upd_is_branch || upd_is_jump);
  // A flush discards the concurrent update outright, so it is neither pushed nor counted.
  assign push  = typed && !flush && (!full || pop);
  assign drop  = typed && !flush && full && !pop;
  assign head  = fifo_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      drop_q  <= '0;
    end else begin
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (flush) begin
        state_q <= CLEAR;
        cnt_q   <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
      end else begin
        if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        if (push) wptr_q <= wptr_q + (AW+1)'(1);
        case (state_q)
          IDLE: state_q <= CLEAR;
          CLEAR: begin
            if (cnt_q == CNT_LAST) begin
              state_q <= RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[AW-1:0]] <= '{is_br: upd_is_branch, taken: upd_taken,
                                          idx: upd_pc[IW+1:2], tgt: upd_target};
  end

  // Write port is a pure decode of registered state and the FIFO head.
  always_comb begin
    btb_we     = 1'b0;
    btb_idx    = '0;
    btb_valid  = 1'b0;
    btb_target = '0;
    pht_we     = 1'b0;
    pht_idx    = '0;
    pht_init   = 1'b0;
    pht_taken  = 1'b0;
    case (state_q)
      CLEAR: begin
        btb_we   = 1'b1;
        btb_idx  = cnt_q;
        pht_we   = ({1'b0, cnt_q} < PHT_LIM);
        pht_idx  = cnt_q[PW-1:0];
        pht_init = 1'b1;
      end
      RUN: begin
        if (!empty) begin
          btb_we     = !head.is_br || head.taken;
          btb_idx    = head.idx;
          btb_valid  = !head.is_br || head.taken;
          btb_target = head.tgt;
          pht_we     = head.is_br;
          pht_idx    = head.idx[PW-1:0];
          pht_taken  = head.taken;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != RUN);
  assign upd_ready = !full;
  assign drop_cnt  = drop_q;
endmodule
